// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - widths and entry type shared by fetch, fetch_queue and decode
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 8;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// rtl/fq_ptr.sv - wrap-around pointer increment for a power-of-two ring
module fq_ptr #(
    parameter int W = 3
) (
    input  logic [W-1:0] ptr,
    output logic [W-1:0] ptr_next
);

    // Natural overflow of a W-bit add gives the DEPTH-1 -> 0 wrap.
    assign ptr_next = ptr + W'(1);

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular instruction buffer between fetch and decode
module fetch_queue #(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    parameter int PC_W    = fetch_pkg::PC_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [PC_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [PC_W+INSTR_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_next;
    logic          push;
    logic          pop;

    // in_ready ignores out_ready: a full queue never takes a write even while popping.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign {out_pc, out_instr} = mem[rd_ptr];

    fq_ptr #(.W(AW)) u_wr_ptr (
        .ptr      (wr_ptr),
        .ptr_next (wr_ptr_next)
    );

    fq_ptr #(.W(AW)) u_rd_ptr (
        .ptr      (rd_ptr),
        .ptr_next (rd_ptr_next)
    );

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {in_pc, in_instr};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_next;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_next;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue model
module tb_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic [3:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_pkg::fq_entry_t q[$];
    bit m_push;
    bit m_pop;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated from the handshake rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else begin
            m_push = in_valid && (q.size() < DEPTH);
            m_pop  = out_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back('{pc: in_pc, instr: in_instr});
            end
        end
    end

    always @(negedge clk) begin
        check("count", 64'(count), 64'(q.size()));
        check("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() > 0) begin
            check("out_pc", 64'(out_pc), 64'(q[0].pc));
            check("out_instr", 64'(out_instr), 64'(q[0].instr));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = 32'hC0DE_0000 | 32'(pc);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        cycle();
        cycle();
        reset = 1'b0;
        check("reset count", 64'(count), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);

        // single pass-through
        in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 8'h00;
        cycle();
        in_valid = 1'b0;
        check("t1 count", 64'(count), 64'd1);
        check("t1 out_valid", 64'(out_valid), 64'd1);
        check("t1 out_instr", 64'(out_instr), 64'h0050_0093);
        check("t1 out_pc", 64'(out_pc), 64'h00);
        drain(1);
        check("t1 count after pop", 64'(count), 64'd0);
        check("t1 out_valid after pop", 64'(out_valid), 64'd0);

        // fill to full, ninth push ignored, drain in order
        for (int i = 0; i < 8; i++) push(8'(i));
        check("t2 count full", 64'(count), 64'd8);
        check("t2 in_ready full", 64'(in_ready), 64'd0);
        push(8'h08);
        check("t2 count after 9th", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("t2 pop order", 64'(out_pc), 64'(i));
            drain(1);
        end
        check("t2 count drained", 64'(count), 64'd0);

        // wrap-around streaming
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_pc    = 8'(8'h10 + k);
            in_instr = 32'hC0DE_0000 | 32'(in_pc);
            cycle();
            check("t3 count", 64'(count), 64'd1);
            check("t3 out_pc", 64'(out_pc), 64'(8'h10 + k));
        end
        in_valid = 1'b0;
        cycle();
        out_ready = 1'b0;
        check("t3 count end", 64'(count), 64'd0);

        // push and pop together when full
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        in_valid = 1'b1; in_pc = 8'h28; in_instr = 32'hC0DE_0028; out_ready = 1'b1;
        cycle();
        check("t4 count after pop", 64'(count), 64'd7);
        check("t4 head", 64'(out_pc), 64'h21);
        out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        check("t4 count refill", 64'(count), 64'd8);
        drain(8);
        check("t4 count drained", 64'(count), 64'd0);

        // flush beats push and pop
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        check("t5 count before flush", 64'(count), 64'd5);
        flush = 1'b1; in_valid = 1'b1; in_pc = 8'h40; in_instr = 32'hC0DE_0040; out_ready = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("t5 count", 64'(count), 64'd0);
        check("t5 out_valid", 64'(out_valid), 64'd0);
        check("t5 in_ready", 64'(in_ready), 64'd1);
        push(8'h41);
        check("t5 next out", 64'(out_pc), 64'h41);
        check("t5 count", 64'(count), 64'd1);
        drain(1);

        // asynchronous reset between edges
        for (int i = 0; i < 3; i++) push(8'(8'h50 + i));
        check("t6 count before reset", 64'(count), 64'd3);
        #1;
        reset = 1'b1;
        #1;
        check("t6 async count", 64'(count), 64'd0);
        check("t6 async out_valid", 64'(out_valid), 64'd0);
        check("t6 async in_ready", 64'(in_ready), 64'd1);
        cycle();
        reset = 1'b0;
        push(8'h60);
        check("t6 after reset", 64'(out_pc), 64'h60);
        drain(1);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and decode. It captures each fetched instruction together with its 8-bit PC and holds up to DEPTH entries in a circular FIFO. It presents the oldest entry to decode through a valid/ready handshake, so fetch and decode can stall independently. A synchronous flush discards all buffered entries on a branch redirect or pipeline squash.

## Interface

Parameters:
- DEPTH, 8: number of entries; must be a power of two and ≥ 2.
- INSTR_W, 32: instruction width in bits.
- PC_W, 8: PC width in bits; matches the fetch PC counter.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous squash of all entries.
- in_valid, input, 1: fetch presents an entry.
- in_ready, output, 1: queue can accept an entry this cycle.
- in_instr, input, INSTR_W: instruction word from fetch.
- in_pc, input, PC_W: PC of in_instr.
- out_valid, output, 1: head entry is valid.
- out_ready, input, 1: decode consumes the head this cycle.
- out_instr, output, INSTR_W: head instruction.
- out_pc, output, PC_W: head PC.
- count, output, clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation

**Storage and pointers**
- Storage is DEPTH × (INSTR_W + PC_W).
- wr_ptr and rd_ptr are clog2(DEPTH) bits wide and wrap naturally from DEPTH−1 to 0.
- count is a separate register.

**Handshake signals**
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It does not depend on out_ready, so a full queue does not accept an entry even when a pop occurs in the same cycle.
- out_valid = (count != 0).
- out_instr and out_pc = storage[rd_ptr]. These are driven directly from storage and are unaffected by same-cycle inputs; there is no empty-queue bypass.

**Per-edge update, in priority order**
1. reset (asynchronous): wr_ptr, rd_ptr and count go to 0. Storage contents are don't-care.
2. flush: wr_ptr, rd_ptr and count go to 0. Any push or pop in the same cycle is discarded. in_ready and out_valid are not gated by flush; a push accepted in a flush cycle is dropped.
3. push only: write storage[wr_ptr], increment wr_ptr, count +1.
4. pop only: increment rd_ptr, count −1.
5. push and pop together (requires 0 < count < DEPTH): write, increment both pointers, count unchanged.

**Invariants**
- FIFO order is strict.
- No entry is duplicated or lost, except on flush.
- count never exceeds DEPTH and never underflows.

## Timing

- Reset values: count = 0, out_valid = 0, in_ready = 1. out_instr and out_pc are undefined until the first write.
- Latency:
  - An entry pushed at edge N is visible on out_* with out_valid = 1 after edge N, provided it is at the head. Minimum latency is 1 cycle.
  - An entry popped at edge N disappears after edge N, and the next entry is presented in the same cycle.
- Throughput is one push and one pop per cycle while 0 < count < DEPTH.
- When full, a push stalls for one cycle after a pop.
- Reset asserted mid-stream clears the queue immediately, without waiting for a clock edge. Deassertion is synchronised externally.
- After a flush at edge N, out_valid = 0 in cycle N+1 and in_ready = 1.

## Structure

- Shared package fetch_pkg holds:
  - INSTR_W = 32 and PC_W = 8, shared with fetch and decode;
  - the typedef fq_entry_t = {pc, instr}.
- Storage is a single register array inside the module; no sub-module is required.
- Optional sub-module fq_ptr: wrap-around pointer increment. It is instantiated twice, for wr_ptr and rd_ptr.

## Test plan

- **Reset and single pass-through.** Reset, then push instr 0x00500093 with pc 0x00 while out_ready = 0. Required: count = 1, out_valid = 1, out_instr = 0x00500093, out_pc = 0x00. Then pulse out_ready. Required: count = 0, out_valid = 0.
- **Fill to full.** Push 8 entries with pc 0x00..0x07 and out_ready = 0. Required: count = 8, in_ready = 0. A ninth push with pc 0x08 is ignored. Then pop all entries. Required: pcs emerge as 0x00..0x07 in order.
- **Wrap-around streaming.** Hold in_valid = out_ready = 1 for 20 cycles with pc incrementing from 0x10. Required: count stays at 1 after the first cycle, out_pc sequence is 0x10, 0x11, …, and both pointers wrap past 7 cleanly.
- **Simultaneous push and pop when full.** With count = 8, drive in_valid = out_ready = 1. Required: the pop occurs, the push is rejected, and count becomes 7. On the next cycle the same push is accepted and count returns to 8.
- **Flush priority.** With count = 5, assert flush together with push of pc 0x40 and pop. Required: count = 0 and out_valid = 0 next cycle. A following push of pc 0x41 is the next entry out.
- **Asynchronous reset mid-operation.** With count = 3, assert reset between clock edges. Required: count = 0 and out_valid = 0 before the next edge, and in_ready = 1.
